// File: rtl/rv32_instr_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder / program loader.
// Opcode values match the control-unit decoder so encoded words round-trip.
package rv32_pkg;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_SLL   = 3'b001;
    localparam logic [2:0] F3_LW_SW = 3'b010;
    localparam logic [2:0] F3_SR    = 3'b101;

    typedef enum logic [1:0] {
        T_R = 2'd0,
        T_L = 2'd1,
        T_S = 2'd2,
        T_I = 2'd3
    } instr_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } enc_state_e;

    // Decoded field bundle; aluop = {func7[5], func3}
    typedef struct packed {
        instr_type_e itype;
        logic [3:0]  aluop;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
    } enc_req_t;

endpackage

// File: rtl/rv32_instr_encoder_if.sv
// Field-bundle handshake plus instruction-memory write bus.
// slave = encoder side, master = producer / memory-model side.
interface rv32_instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_type;
    logic [3:0]        in_aluop;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [11:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport slave (
        input  in_valid, in_type, in_aluop, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output in_valid, in_type, in_aluop, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/rv32_instr_encoder_pack.sv
// Combinational field packer: decoded bundle -> 32-bit R/L/S/I word plus
// an illegal flag for combinations the core would not decode.
module rv32_instr_pack
    import rv32_pkg::*;
(
    input  enc_req_t    req,
    output logic [31:0] word,
    output logic        illegal
);
    logic [2:0] f3;
    logic       f7b;

    assign f3  = req.aluop[2:0];
    assign f7b = req.aluop[3];

    // Format select; shifts carry func7[5] above a 5-bit shamt
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (req.itype)
            T_R: begin
                word    = {1'b0, f7b, 5'b0, req.rs2, req.rs1, f3, req.rd, OP_R};
                illegal = f7b && (f3 != F3_ADD) && (f3 != F3_SR);
            end
            T_L: begin
                word    = {req.imm, req.rs1, F3_LW_SW, req.rd, OP_L};
                illegal = (f3 != F3_LW_SW);
            end
            T_S: begin
                word    = {req.imm[11:5], req.rs2, req.rs1, F3_LW_SW, req.imm[4:0], OP_S};
                illegal = (f3 != F3_LW_SW);
            end
            T_I: begin
                if (f3 == F3_SLL || f3 == F3_SR)
                    word = {1'b0, f7b, 5'b0, req.imm[4:0], req.rs1, f3, req.rd, OP_I};
                else
                    word = {req.imm, req.rs1, f3, req.rd, OP_I};
                illegal = f7b && (f3 != F3_SR);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/rv32_instr_encoder.sv
// Streaming RV32I encoder / program loader. Packs field bundles and writes
// them sequentially to instruction memory, one cycle after acceptance.
// Optional: define IMEM_CHECKSUM_EN to add a running XOR checksum output.
module rv32_instr_encoder
    import rv32_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              MEM_DEPTH = 64,
    localparam int             CW        = $clog2(MEM_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  finish,
    rv32_instr_encoder_if.slave   bus,
    output logic [CW-1:0]         word_count,
    output logic                  busy,
    output logic                  done,
`ifdef IMEM_CHECKSUM_EN
    output logic [31:0]           checksum,
`endif
    output logic                  err_illegal
);
    localparam logic [CW-1:0] LAST_CNT = CW'(MEM_DEPTH - 1);

    enc_state_e        state, state_n;
    enc_req_t          req;
    logic [31:0]       word;
    logic              illegal;
    logic              accept, last, restart;
    logic [CW-1:0]     acc_cnt;
    logic [ADDR_W-1:0] addr_cnt;

    assign req = '{itype: instr_type_e'(bus.in_type), aluop: bus.in_aluop,
                   rd: bus.in_rd, rs1: bus.in_rs1, rs2: bus.in_rs2, imm: bus.in_imm};

    rv32_instr_pack u_pack (
        .req     (req),
        .word    (word),
        .illegal (illegal)
    );

    assign bus.in_ready = (state == LOAD);
    assign busy         = (state == LOAD);
    assign done         = (state == DONE);
    assign accept       = bus.in_valid && bus.in_ready;
    // Illegal accepts count too, so the limit is on bundles, not words
    assign last         = accept && (acc_cnt == LAST_CNT);
    assign restart      = start && (state != DONE);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next state: start in LOAD restarts, start in DONE is ignored
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = LOAD;
            LOAD:    if (!start && (finish || last)) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Write register and session counters; a write accepted alongside a
    // restart still uses the pre-restart address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            addr_cnt       <= '0;
            acc_cnt        <= '0;
            word_count     <= '0;
            err_illegal    <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            checksum       <= '0;
`endif
        end else begin
            bus.imem_we <= accept && !illegal;
            if (accept && !illegal) begin
                bus.imem_addr  <= addr_cnt;
                bus.imem_wdata <= word;
            end
            if (restart) begin
                addr_cnt    <= BASE_ADDR;
                acc_cnt     <= '0;
                word_count  <= '0;
                err_illegal <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
                checksum    <= '0;
`endif
            end else if (accept) begin
                acc_cnt <= acc_cnt + 1'b1;
                if (illegal) begin
                    err_illegal <= 1'b1;
                end else begin
                    addr_cnt   <= addr_cnt + ADDR_W'(4);
                    word_count <= word_count + 1'b1;
`ifdef IMEM_CHECKSUM_EN
                    checksum   <= checksum ^ word;
`endif
                end
            end
        end
    end
endmodule
